calc_result_display: RTL
========================

// Module: calc_result_display
// PURPOSE
//  Consumer of the calculator's result interface: captures the 16-bit result and overflow flag
//  when Load pulses, converts the result to BCD with a sequential shift-add-3 engine, and drives
//  a 4-digit multiplexed, active-low seven-segment display.
//  Sits between the calculator core (C, Flag, QDone, QErr) and the board's An/Ssd/Dp pins.
// PARAMETERS
//  REFRESH_BITS  18  width of the scan counter; bits [REFRESH_BITS-1:REFRESH_BITS-2] select the digit
// PORTS
//  Clk     in   1   system clock
//  Reset   in   1   asynchronous, active-high reset
//  Result  in   16  unsigned value to show (calculator C[15:0])
//  Flag    in   1   overflow flag, sampled with Result
//  Load    in   1   one-cycle strobe: capture Result/Flag and start conversion
//  Err     in   1   level: while high, display shows "Err " (calculator QErr)
//  Busy    out  1   high while conversion is in progress
//  Ready   out  1   high once a conversion has completed; cleared by Load
//  An      out  4   digit anodes, active-low, one-hot low; An[3] = leftmost digit
//  Ssd     out  7   segments, active-low, Ssd[6:0] = {a,b,c,d,e,f,g}
//  Dp      out  1   decimal point, active-low
// BEHAVIOUR
//  Reset values: An=4'b1111, Ssd=7'b1111111, Dp=1, Busy=0, Ready=0; FSM=IDLE; scan counter=0;
//   digit register = 4 x BLANK.
//  FSM states:
//   - IDLE: Load -> CONV.
//   - CONV: 16 iterations, one per Clk. Each iteration adds 3 to every BCD nibble >=5, then shifts
//     {bcd[19:0], bin[15:0]} left by 1. Iteration counter is 0..15; after 15 -> DONE.
//   - DONE: Load -> CONV.
//  Load in any state, including CONV, recaptures Result/Flag, zeroes the BCD register,
//   resets the iteration counter, clears Ready and enters CONV. The latest Load wins.
//  Latency: Load sampled at edge 0 -> Busy=1 from edge 0 through edge 16.
//   The digit register updates at edge 16 -> Busy=0 and Ready=1 after edge 16.
//  Digit register update on completion:
//   - ten-thousands nibble != 0 (value > 9999) -> "----".
//   - otherwise the 4 low BCD digits, with leading zeros blanked; the ones digit always shows
//     (0 shows as "   0").
//   - DpFlag <= captured Flag.
//  Err=1 overrides the display with {E,r,r,BLANK} and Dp off. Err does not stop or corrupt an
//   ongoing conversion; when Err falls, the stored digit register reappears.
//  Scan: free-running counter wraps at 2^REFRESH_BITS.
//   - sel=3..0 -> An has a single 0 at bit sel; Ssd = encode(digit[sel]).
//   - Dp=0 only when sel==3 and DpFlag=1 and Err=0.
//   - Outputs are registered, one cycle behind sel.
//  Segment codes: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000,
//   7=0001111, 8=0000000, 9=0000100, DASH=1111110, E=0110000, r=1111010, BLANK=1111111.
//  Reset mid-conversion: return to reset values immediately; no partial result is displayed.
// CONFIGURATION
//  CALC_DISP_HEX_EN defined:
//   - adds input HexSel (1 bit). If HexSel=1 when Load is sampled, the conversion is skipped:
//     the digits are Result[15:12..3:0] as hex with no blanking (A=0001000, b=1100000,
//     C=0110001, d=1000010, E=0110000, F=0111000).
//   - Busy stays 0 and Ready=1 after edge 0 (1-cycle latency).
//  CALC_DISP_HEX_EN undefined: no HexSel port; decimal path only.
// TESTING
//  1. Assert Reset -> An=1111, Ssd=1111111, Dp=1, Busy=0, Ready=0.
//  2. Result=16'd1234, Load 1 cycle -> Busy 16 cycles, Ready=1;
//     scan An=0111/1011/1101/1110 shows Ssd 1001111/0010010/0000110/1001100.
//  3. Result=16'd7, Flag=1, Load -> digits BLANK,BLANK,BLANK,7; Dp=0 only when An=0111.
//  4. Result=16'd65535, Load -> all four digits 1111110 (DASH); Ready=1.
//  5. Result=16'd500, Load; 5 cycles later Result=16'd42, Load -> completes 16 cycles after the
//     second Load and shows "  42". Err=1 -> "Err " with Dp=1; Err=0 -> "  42" returns.
//  6. Load with Result=9999, Reset at CONV cycle 8 -> all outputs at reset values;
//     Busy=0 and the display stays blank.
//  7. (CALC_DISP_HEX_EN) HexSel=1, Result=16'hBEEF, Load -> Ready after 1 cycle;
//     digits b,E,E,F.

Source files
------------

// File: rtl/calc_result_display.sv
// Result display for the calculator: captures a 16-bit result on Load, converts it to BCD with a
// shift-add-3 engine and scans it onto a 4-digit active-low seven-segment display.
// Optional hex bypass path is enabled by defining CALC_DISP_HEX_EN (adds the HexSel input).
module calc_result_display #(
    parameter int REFRESH_BITS = 18
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] Result,
    input  logic        Flag,
    input  logic        Load,
    input  logic        Err,
`ifdef CALC_DISP_HEX_EN
    input  logic        HexSel,
`endif
    output logic        Busy,
    output logic        Ready,
    output logic [3:0]  An,
    output logic [6:0]  Ssd,
    output logic        Dp
);

    typedef enum logic [1:0] {IDLE, CONV, DONE} stateT;

    // Symbols 0..15 are hex digits; the rest are the non-numeric glyphs.
    localparam logic [4:0] SYM_E     = 5'd14;
    localparam logic [4:0] SYM_BLANK = 5'd16;
    localparam logic [4:0] SYM_DASH  = 5'd17;
    localparam logic [4:0] SYM_R     = 5'd18;

    stateT state, stateNext;

    logic [15:0] binReg;
    logic [19:0] bcdReg;
    logic [3:0]  iterCnt;
    logic        flagReg;
    logic        dpFlag;
    logic [3:0][4:0] digitReg;

    logic [19:0] bcdAdj;
    logic [19:0] bcdNext;
    logic [15:0] binNext;
    logic        lastIter;
    logic        hexLoad;
    logic        tooLarge;
    logic [3:0][4:0] decDigits;

    logic [REFRESH_BITS-1:0] scanCnt;
    logic [1:0]  sel;
    logic [4:0]  shownSym;

    function automatic logic [19:0] addThree(input logic [19:0] bcd);
        logic [19:0] res;
        logic [3:0]  nib;
        res = bcd;
        for (int i = 0; i < 5; i++) begin
            nib = bcd[4*i +: 4];
            if (nib >= 4'd5) begin
                nib = nib + 4'd3;
            end
            res[4*i +: 4] = nib;
        end
        return res;
    endfunction

    function automatic logic [6:0] encodeSym(input logic [4:0] sym);
        logic [6:0] seg;
        case (sym)
            5'd0:     seg = 7'b0000001;
            5'd1:     seg = 7'b1001111;
            5'd2:     seg = 7'b0010010;
            5'd3:     seg = 7'b0000110;
            5'd4:     seg = 7'b1001100;
            5'd5:     seg = 7'b0100100;
            5'd6:     seg = 7'b0100000;
            5'd7:     seg = 7'b0001111;
            5'd8:     seg = 7'b0000000;
            5'd9:     seg = 7'b0000100;
            5'd10:    seg = 7'b0001000;
            5'd11:    seg = 7'b1100000;
            5'd12:    seg = 7'b0110001;
            5'd13:    seg = 7'b1000010;
            5'd14:    seg = 7'b0110000;
            5'd15:    seg = 7'b0111000;
            SYM_DASH: seg = 7'b1111110;
            SYM_R:    seg = 7'b1111010;
            default:  seg = 7'b1111111;
        endcase
        return seg;
    endfunction

`ifdef CALC_DISP_HEX_EN
    assign hexLoad = Load && HexSel;
`else
    assign hexLoad = 1'b0;
`endif

    // One shift-add-3 step on the combined {bcd, bin} register.
    always_comb begin
        bcdAdj   = addThree(bcdReg);
        bcdNext  = {bcdAdj[18:0], binReg[15]};
        binNext  = {binReg[14:0], 1'b0};
        lastIter = (iterCnt == 4'd15);
    end

    // Final digit pattern, built from the result of the last conversion step.
    always_comb begin
        tooLarge  = (bcdNext[19:16] != 4'd0) || bcdAdj[19];
        decDigits = {4{SYM_BLANK}};
        if (tooLarge) begin
            decDigits = {4{SYM_DASH}};
        end else begin
            decDigits[0] = {1'b0, bcdNext[3:0]};
            if (bcdNext[15:12] != 4'd0) begin
                decDigits[3] = {1'b0, bcdNext[15:12]};
            end
            if (bcdNext[15:8] != 8'd0) begin
                decDigits[2] = {1'b0, bcdNext[11:8]};
            end
            if (bcdNext[15:4] != 12'd0) begin
                decDigits[1] = {1'b0, bcdNext[7:4]};
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        if (Load) begin
            stateNext = hexLoad ? DONE : CONV;
        end else if (state == CONV && lastIter) begin
            stateNext = DONE;
        end
    end

    always_comb begin
        Busy  = (state == CONV);
        Ready = (state == DONE);
    end

    // A new Load always restarts the engine, even mid-conversion.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            binReg   <= '0;
            bcdReg   <= '0;
            iterCnt  <= '0;
            flagReg  <= 1'b0;
            dpFlag   <= 1'b0;
            digitReg <= {4{SYM_BLANK}};
        end else if (Load) begin
            binReg  <= Result;
            bcdReg  <= '0;
            iterCnt <= '0;
            flagReg <= Flag;
            if (hexLoad) begin
                digitReg <= {{1'b0, Result[15:12]}, {1'b0, Result[11:8]},
                             {1'b0, Result[7:4]},   {1'b0, Result[3:0]}};
                dpFlag   <= Flag;
            end
        end else if (state == CONV) begin
            binReg  <= binNext;
            bcdReg  <= bcdNext;
            iterCnt <= iterCnt + 4'd1;
            if (lastIter) begin
                digitReg <= decDigits;
                dpFlag   <= flagReg;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            scanCnt <= '0;
        end else begin
            scanCnt <= scanCnt + 1'b1;
        end
    end

    assign sel = scanCnt[REFRESH_BITS-1 -: 2];

    // Err only masks what is shown; the stored digits are left untouched.
    always_comb begin
        shownSym = digitReg[sel];
        if (Err) begin
            case (sel)
                2'd3:    shownSym = SYM_E;
                2'd2:    shownSym = SYM_R;
                2'd1:    shownSym = SYM_R;
                default: shownSym = SYM_BLANK;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            An  <= 4'b1111;
            Ssd <= 7'b1111111;
            Dp  <= 1'b1;
        end else begin
            An  <= ~(4'b0001 << sel);
            Ssd <= encodeSym(shownSym);
            Dp  <= !((sel == 2'd3) && dpFlag && !Err);
        end
    end

endmodule
